// File: rtl/forwarding_unit_gen_pkg.sv
// Shared constants for the EXE-stage forwarding/hazard unit: select codes
// and the load-use stall FSM state encoding.
package forwarding_unit_gen_pkg;

  localparam int REG_FILE_ADDR_LEN = 5;
  localparam int FORW_SEL_LEN      = 2;

  localparam logic [FORW_SEL_LEN-1:0] FWD_SEL_RF   = 2'd0;
  localparam logic [FORW_SEL_LEN-1:0] FWD_SEL_MEM  = 2'd1;
  localparam logic [FORW_SEL_LEN-1:0] FWD_SEL_WB   = 2'd2;
  localparam logic [FORW_SEL_LEN-1:0] FWD_SEL_HIST = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } hz_state_t;

endpackage

// File: rtl/forwarding_unit_gen_fwd_history_buf.sv
// Retired-writeback history: entry k holds the WB write from k+1 cycles ago,
// with one newest-first lookup port per EXE operand.
module fwd_history_buf #(
  parameter int NUM_SRC    = 3,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int HIST_DEPTH = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_wr_en,
  input  logic [ADDR_W-1:0]         i_wr_addr,
  input  logic [DATA_W-1:0]         i_wr_data,
  input  logic [NUM_SRC*ADDR_W-1:0] i_rd_addr,
  output logic [NUM_SRC-1:0]        o_hit,
  output logic [NUM_SRC*DATA_W-1:0] o_data
);

  logic [HIST_DEPTH-1:0] r_vld;
  logic [ADDR_W-1:0]     r_addr [HIST_DEPTH];
  logic [DATA_W-1:0]     r_data [HIST_DEPTH];

  // An empty slot is pushed on idle cycles so entry age stays fixed.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int k = 0; k < HIST_DEPTH; k++) begin
        r_addr[k] <= '0;
        r_data[k] <= '0;
      end
    end else begin
      r_vld[0]  <= i_wr_en && (i_wr_addr != '0);
      r_addr[0] <= i_wr_addr;
      r_data[0] <= i_wr_data;
      for (int k = 1; k < HIST_DEPTH; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_addr[k] <= r_addr[k-1];
        r_data[k] <= r_data[k-1];
      end
    end
  end

  // Scan oldest to newest so the newest matching entry is the last written.
  always_comb begin
    o_hit  = '0;
    o_data = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = HIST_DEPTH - 1; k >= 0; k--) begin
        if (r_vld[k] && (r_addr[k] == i_rd_addr[i*ADDR_W +: ADDR_W]) &&
            (i_rd_addr[i*ADDR_W +: ADDR_W] != '0)) begin
          o_hit[i]                  = 1'b1;
          o_data[i*DATA_W +: DATA_W] = r_data[k];
        end
      end
    end
  end

endmodule

// File: rtl/forwarding_unit_gen.sv
// EXE-stage forwarding select and load-use stall FSM. Forwarding and the
// history buffer exist only when FORWARDING_EN is defined; otherwise RAW stalls.
//
// state   | meaning
// IDLE    | no stall in progress; stall follows the combinational detect
// HOLD    | extra load-latency stall cycles, counted down in r_cnt
module forwarding_unit_gen
  import forwarding_unit_gen_pkg::*;
#(
  parameter int NUM_SRC    = 3,
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int HIST_DEPTH = 2,
  parameter int LOAD_LAT   = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_SRC*ADDR_W-1:0] src_EXE,
  input  logic [NUM_SRC*DATA_W-1:0] src_val_EXE,
  input  logic [ADDR_W-1:0]         dest_MEM,
  input  logic [ADDR_W-1:0]         dest_WB,
  input  logic                      WB_EN_MEM,
  input  logic                      WB_EN_WB,
  input  logic [DATA_W-1:0]         val_MEM,
  input  logic [DATA_W-1:0]         val_WB,
  input  logic [NUM_SRC*ADDR_W-1:0] src_ID,
  input  logic [NUM_SRC-1:0]        src_used_ID,
  input  logic [ADDR_W-1:0]         dest_EXE,
  input  logic                      WB_EN_EXE,
  input  logic                      MEM_R_EN_EXE,
  output logic [NUM_SRC*2-1:0]      fwd_sel,
  output logic [NUM_SRC*DATA_W-1:0] fwd_val,
  output logic                      hazard_stall
);

  localparam int CNT_W = $clog2(LOAD_LAT + 1);

  hz_state_t        r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             w_load_use;
  logic             w_raw_hz;
  logic             w_stall;

  always_comb begin
    w_load_use = 1'b0;
    if (MEM_R_EN_EXE && WB_EN_EXE && (dest_EXE != '0)) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (src_used_ID[i] && (src_ID[i*ADDR_W +: ADDR_W] == dest_EXE))
          w_load_use = 1'b1;
      end
    end
  end

`ifdef FORWARDING_EN
  logic [NUM_SRC-1:0]        w_hist_hit;
  logic [NUM_SRC*DATA_W-1:0] w_hist_data;

  fwd_history_buf #(
    .NUM_SRC    (NUM_SRC),
    .ADDR_W     (ADDR_W),
    .DATA_W     (DATA_W),
    .HIST_DEPTH (HIST_DEPTH)
  ) u_hist (
    .clk       (clk),
    .rst       (rst),
    .i_wr_en   (WB_EN_WB),
    .i_wr_addr (dest_WB),
    .i_wr_data (val_WB),
    .i_rd_addr (src_EXE),
    .o_hit     (w_hist_hit),
    .o_data    (w_hist_data)
  );

  always_comb begin
    fwd_sel = '0;
    fwd_val = src_val_EXE;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_EXE[i*ADDR_W +: ADDR_W] != '0) begin
        if (WB_EN_MEM && (dest_MEM == src_EXE[i*ADDR_W +: ADDR_W])) begin
          fwd_sel[i*2 +: 2]          = FWD_SEL_MEM;
          fwd_val[i*DATA_W +: DATA_W] = val_MEM;
        end else if (WB_EN_WB && (dest_WB == src_EXE[i*ADDR_W +: ADDR_W])) begin
          fwd_sel[i*2 +: 2]          = FWD_SEL_WB;
          fwd_val[i*DATA_W +: DATA_W] = val_WB;
        end else if (w_hist_hit[i]) begin
          fwd_sel[i*2 +: 2]          = FWD_SEL_HIST;
          fwd_val[i*DATA_W +: DATA_W] = w_hist_data[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  assign w_raw_hz = 1'b0;
`else
  logic w_unused;
  assign w_unused = ^{val_MEM, val_WB, src_EXE};

  assign fwd_sel = {NUM_SRC{FWD_SEL_RF}};
  assign fwd_val = src_val_EXE;

  // Without forwarding, any in-flight producer of a used ID source must stall.
  always_comb begin
    w_raw_hz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (src_used_ID[i] && (src_ID[i*ADDR_W +: ADDR_W] != '0)) begin
        if ((WB_EN_EXE && (dest_EXE == src_ID[i*ADDR_W +: ADDR_W])) ||
            (WB_EN_MEM && (dest_MEM == src_ID[i*ADDR_W +: ADDR_W])) ||
            (WB_EN_WB  && (dest_WB  == src_ID[i*ADDR_W +: ADDR_W])))
          w_raw_hz = 1'b1;
      end
    end
  end
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_stall     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_stall = w_load_use || w_raw_hz;
        if (w_load_use && (LOAD_LAT > 1)) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = CNT_W'(LOAD_LAT - 1);
        end
      end
      ST_HOLD: begin
        w_stall   = 1'b1;
        w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt == CNT_W'(1))
          w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  assign hazard_stall = rst ? 1'b0 : w_stall;

endmodule

// File: tb/tb_forwarding_unit_gen.sv
// Directed bench for forwarding_unit_gen (LOAD_LAT=3, HIST_DEPTH=2); the
// forwarding checks follow whether FORWARDING_EN is defined.
module tb_forwarding_unit_gen;

  localparam int NS = 3;
  localparam int AW = 5;
  localparam int DW = 32;

  logic             clk = 1'b0;
  logic             rst;
  logic [NS*AW-1:0] src_EXE;
  logic [NS*DW-1:0] src_val_EXE;
  logic [AW-1:0]    dest_MEM, dest_WB, dest_EXE;
  logic             WB_EN_MEM, WB_EN_WB, WB_EN_EXE, MEM_R_EN_EXE;
  logic [DW-1:0]    val_MEM, val_WB;
  logic [NS*AW-1:0] src_ID;
  logic [NS-1:0]    src_used_ID;
  logic [NS*2-1:0]  fwd_sel;
  logic [NS*DW-1:0] fwd_val;
  logic             hazard_stall;

  int n_total = 0;
  int n_bad   = 0;

  localparam logic [NS*DW-1:0] SRC_VALS = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111};

  forwarding_unit_gen #(
    .NUM_SRC(NS), .ADDR_W(AW), .DATA_W(DW), .HIST_DEPTH(2), .LOAD_LAT(3)
  ) dut (
    .clk(clk), .rst(rst), .src_EXE(src_EXE), .src_val_EXE(src_val_EXE),
    .dest_MEM(dest_MEM), .dest_WB(dest_WB), .WB_EN_MEM(WB_EN_MEM),
    .WB_EN_WB(WB_EN_WB), .val_MEM(val_MEM), .val_WB(val_WB),
    .src_ID(src_ID), .src_used_ID(src_used_ID), .dest_EXE(dest_EXE),
    .WB_EN_EXE(WB_EN_EXE), .MEM_R_EN_EXE(MEM_R_EN_EXE),
    .fwd_sel(fwd_sel), .fwd_val(fwd_val), .hazard_stall(hazard_stall)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic clr_inputs();
    src_EXE = '0; src_val_EXE = SRC_VALS;
    dest_MEM = '0; dest_WB = '0; dest_EXE = '0;
    WB_EN_MEM = 0; WB_EN_WB = 0; WB_EN_EXE = 0; MEM_R_EN_EXE = 0;
    val_MEM = '0; val_WB = '0; src_ID = '0; src_used_ID = '0;
  endtask

  // Advance to just after the next rising edge; checks happen 4 ns later.
  task automatic next_cyc();
    @(posedge clk); #1;
  endtask

  task automatic set_load_use(input logic used);
    MEM_R_EN_EXE = 1; WB_EN_EXE = 1; dest_EXE = 5'd5;
    src_ID = {5'd0, 5'd5, 5'd9}; src_used_ID = {1'b0, used, 1'b1};
  endtask

  logic exp_raw;

  initial begin
`ifdef FORWARDING_EN
    exp_raw = 1'b0;
`else
    exp_raw = 1'b1;
`endif
    clr_inputs();
    rst = 1;
    next_cyc(); next_cyc();
    set_load_use(1'b1);
    #4;
    chk("rst_stall", {127'd0, hazard_stall}, 128'd0);
    chk("rst_sel", {122'd0, fwd_sel}, 128'd0);
    chk("rst_val", {32'd0, fwd_val}, {32'd0, SRC_VALS});
    next_cyc(); rst = 0; clr_inputs();

    // Priority: MEM r3 beats WB r3, r0 never forwarded even with dest_MEM=0.
    src_EXE = {5'd0, 5'd3, 5'd3};
    WB_EN_MEM = 1; dest_MEM = 5'd3; val_MEM = 32'h11;
    WB_EN_WB  = 1; dest_WB  = 5'd3; val_WB  = 32'h22;
    #4;
`ifdef FORWARDING_EN
    chk("prio_sel", {122'd0, fwd_sel}, {122'd0, 6'b00_01_01});
    chk("prio_val", {32'd0, fwd_val}, {32'd0, 32'h3333_3333, 32'h11, 32'h11});
`else
    chk("prio_sel", {122'd0, fwd_sel}, 128'd0);
    chk("prio_val", {32'd0, fwd_val}, {32'd0, SRC_VALS});
`endif
    next_cyc();
    WB_EN_MEM = 1; dest_MEM = 5'd0; val_MEM = 32'h55; WB_EN_WB = 0;
    src_EXE = {5'd0, 5'd0, 5'd0};
    #4;
    chk("r0_sel", {122'd0, fwd_sel}, 128'd0);

    // History r7, then idle; visible for HIST_DEPTH cycles.
    next_cyc(); clr_inputs();
    WB_EN_WB = 1; dest_WB = 5'd7; val_WB = 32'hAB;
    next_cyc(); clr_inputs();
    src_EXE = {5'd0, 5'd0, 5'd7};
    #4;
`ifdef FORWARDING_EN
    chk("hist1_sel", {122'd0, fwd_sel}, {122'd0, 6'b00_00_11});
    chk("hist1_val", {96'd0, fwd_val[31:0]}, {96'd0, 32'hAB});
`else
    chk("hist1_sel", {122'd0, fwd_sel}, 128'd0);
    chk("hist1_val", {96'd0, fwd_val[31:0]}, {96'd0, 32'h1111_1111});
`endif
    next_cyc(); #4;
`ifdef FORWARDING_EN
    chk("hist2_sel", {122'd0, fwd_sel}, {122'd0, 6'b00_00_11});
`else
    chk("hist2_sel", {122'd0, fwd_sel}, 128'd0);
`endif
    next_cyc(); #4;
    chk("hist_gone_sel", {122'd0, fwd_sel}, 128'd0);

    // History ordering: r4=1 then r4=2, newest wins.
    next_cyc(); clr_inputs();
    WB_EN_WB = 1; dest_WB = 5'd4; val_WB = 32'd1;
    next_cyc(); val_WB = 32'd2;
    next_cyc(); clr_inputs();
    src_EXE = {5'd0, 5'd4, 5'd0};
    #4;
`ifdef FORWARDING_EN
    chk("hist_order", {96'd0, fwd_val[63:32]}, {96'd0, 32'd2});
`else
    chk("hist_order", {96'd0, fwd_val[63:32]}, {96'd0, 32'h2222_2222});
`endif

    // RAW hazards without load: stall only when forwarding is absent.
    next_cyc(); clr_inputs();
    WB_EN_MEM = 1; dest_MEM = 5'd2; src_ID = {5'd0, 5'd2, 5'd0}; src_used_ID = 3'b010;
    #4;
    chk("raw_mem_stall", {127'd0, hazard_stall}, {127'd0, exp_raw});
    chk("raw_mem_sel", {122'd0, fwd_sel}, 128'd0);
    next_cyc(); src_used_ID = 3'b101;
    #4;
    chk("raw_unused", {127'd0, hazard_stall}, 128'd0);
    next_cyc(); clr_inputs();
    WB_EN_WB = 1; dest_WB = 5'd9; src_ID = {5'd9, 5'd0, 5'd0}; src_used_ID = 3'b100;
    #4;
    chk("raw_wb_stall", {127'd0, hazard_stall}, {127'd0, exp_raw});
    next_cyc(); clr_inputs();
    WB_EN_EXE = 1; dest_EXE = 5'd6; src_ID = {5'd0, 5'd0, 5'd6}; src_used_ID = 3'b001;
    #4;
    chk("raw_exe_stall", {127'd0, hazard_stall}, {127'd0, exp_raw});
    next_cyc(); WB_EN_EXE = 0;
    #4;
    chk("raw_exe_noen", {127'd0, hazard_stall}, 128'd0);
    next_cyc(); clr_inputs();
    WB_EN_MEM = 1; dest_MEM = 5'd0; src_ID = '0; src_used_ID = 3'b111;
    #4;
    chk("raw_r0", {127'd0, hazard_stall}, 128'd0);

    // Load-use, LOAD_LAT=3: stall exactly three cycles.
    next_cyc(); clr_inputs();
    set_load_use(1'b1);
    #4; chk("ld_c0", {127'd0, hazard_stall}, 128'd1);
    next_cyc(); clr_inputs();
    #4; chk("ld_c1", {127'd0, hazard_stall}, 128'd1);
    next_cyc();
    #4; chk("ld_c2", {127'd0, hazard_stall}, 128'd1);
    next_cyc();
    #4; chk("ld_c3", {127'd0, hazard_stall}, 128'd0);

    // Same load, but the matching operand is not really read.
    next_cyc(); clr_inputs();
    set_load_use(1'b0);
    src_ID = {5'd0, 5'd5, 5'd9};
    #4; chk("ld_unused", {127'd0, hazard_stall}, 128'd0);
    next_cyc(); clr_inputs();
    #4; chk("ld_unused_c1", {127'd0, hazard_stall}, 128'd0);

    // Reset during the second stall cycle.
    next_cyc(); clr_inputs();
    WB_EN_WB = 1; dest_WB = 5'd8; val_WB = 32'hCD;
    #4;
    next_cyc(); clr_inputs();
    set_load_use(1'b1);
    #4; chk("rh_c0", {127'd0, hazard_stall}, 128'd1);
    next_cyc(); clr_inputs(); rst = 1;
    #4; chk("rh_rst_stall", {127'd0, hazard_stall}, 128'd0);
    next_cyc(); rst = 0;
    src_EXE = {5'd0, 5'd0, 5'd8};
    #4;
    chk("rh_after_stall", {127'd0, hazard_stall}, 128'd0);
    chk("rh_after_sel", {122'd0, fwd_sel}, 128'd0);
    next_cyc();
    #4; chk("rh_after2_stall", {127'd0, hazard_stall}, 128'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/forwarding_unit_gen.md
Name: forwarding_unit_gen

Overview:
- Parametrised EXE-stage forwarding and hazard unit for the MIPS pipeline.
- Generalises the two-source MEM/WB forwarding selection to NUM_SRC operands.
- Adds a HIST_DEPTH-deep writeback history buffer, which covers register-file write/read races.
- Adds a load-use stall FSM with configurable load latency, and outputs both per-operand select codes and the forwarded operand values.

Parameters:
- NUM_SRC, 3, number of EXE source operands (val1, val2, store value).
- ADDR_W, 5, register address width.
- DATA_W, 32, datapath width.
- HIST_DEPTH, 2, retired-writeback history entries (>=1).
- LOAD_LAT, 1, stall cycles per load-use hazard (>=1).

Ports:
- clk  in  1  clock; everything is sampled on the rising edge.
- rst  in  1  synchronous, active-high reset.
- src_EXE  in  NUM_SRC*ADDR_W  source register numbers in EXE; operand i is at [i*ADDR_W +: ADDR_W].
- src_val_EXE  in  NUM_SRC*DATA_W  register-file values read for each operand.
- dest_MEM, dest_WB  in  ADDR_W each  destination register in MEM / WB.
- WB_EN_MEM, WB_EN_WB  in  1 each  writeback enable in MEM / WB.
- val_MEM, val_WB  in  DATA_W each  result in MEM (ALU result) / WB (final value).
- src_ID  in  NUM_SRC*ADDR_W  source registers of the instruction in ID.
- src_used_ID  in  NUM_SRC  per-operand "really read" mask for the ID instruction.
- dest_EXE  in  ADDR_W  destination register in EXE.
- WB_EN_EXE, MEM_R_EN_EXE  in  1 each  EXE writeback enable / EXE is a load.
- fwd_sel  out  NUM_SRC*2  per-operand select code: 0 regfile, 1 MEM, 2 WB, 3 history.
- fwd_val  out  NUM_SRC*DATA_W  per-operand selected value.
- hazard_stall  out  1  freeze PC/IF/ID and insert a bubble into EXE.

Behaviour:
- Reset (rst=1 at an edge): FSM goes to IDLE, stall counter to 0, all history valid bits to 0.
- While rst=1, hazard_stall is forced to 0.
- fwd_sel and fwd_val are combinational and carry no reset value; with empty history and no MEM/WB matches they equal 0 and src_val_EXE.
- Match rule: an operand matches a producer only if that producer's enable is 1, its dest equals the operand's src, and its dest is not 0. Register 0 is never forwarded.
- Priority per operand, fixed: MEM, then WB, then history (newest entry first), then regfile. All operands are resolved independently.
- fwd_val is val_MEM, val_WB, the matching history data, or src_val_EXE according to fwd_sel.
- History buffer: a shift register clocked every cycle, rst excepted.
  - Entry 0 is loaded with {WB_EN_WB && dest_WB!=0, dest_WB, val_WB}; older entries shift by one; the oldest entry is dropped.
  - An invalid entry is pushed when no write occurs, so entry k is always a write from k+1 cycles ago.
  - Two history entries with the same dest: the lower index (newer) wins.
- Load-use detect (combinational): MEM_R_EN_EXE && WB_EN_EXE && dest_EXE!=0 && some i has src_used_ID[i] && src_ID[i]==dest_EXE.
- FSM state IDLE:
  - hazard_stall = detect.
  - If detect and LOAD_LAT>1: load cnt = LOAD_LAT-1 and go to HOLD.
- FSM state HOLD:
  - hazard_stall = 1 and cnt decrements each cycle.
  - When cnt==1 at an edge, return to IDLE.
  - New detects are ignored in HOLD, since EXE then holds a bubble.
- The total stall length is exactly LOAD_LAT cycles per load-use hazard, and detect deasserts afterwards because the load has left EXE.
- rst asserted mid-HOLD: the FSM returns to IDLE at that edge and the stall drops in the same cycle.
- Latency: forwarding takes 0 cycles. A history entry becomes visible one cycle after its WB write.

Optional Feature:
- Macro FORWARDING_EN.
- Defined: behaviour as above.
- Undefined:
  - fwd_sel is always 0 and fwd_val = src_val_EXE. The history buffer is not instantiated.
  - hazard_stall also asserts combinationally (in IDLE) whenever a used ID source matches the enabled, nonzero dest of EXE, MEM or WB.
  - The load FSM is unchanged.

Decomposition:
- Shared defines hold REG_FILE_ADDR_LEN, FORW_SEL_LEN (=2), and the select codes FWD_SEL_RF/MEM/WB/HIST.
- One sub-module, fwd_history_buf: holds the shift register plus a per-lookup match/priority encoder that returns hit and data for one address.
- fwd_history_buf is instantiated once per operand lookup port, or exposes NUM_SRC lookup ports.

Test Plan:
- Priority: src_EXE={r3,r3,r0}; MEM writes r3=0x11, WB writes r3=0x22 -> sel={1,1,0}, val={0x11,0x11,src_val}; r0 is never forwarded even if dest_MEM=0.
- History: WB writes r7=0xAB at cycle n, then idle; src1=r7 at n+1 -> sel 3, val 0xAB. At n+1+HIST_DEPTH -> sel 0.
- History ordering: WB writes r4=1 then r4=2 on consecutive cycles, no match in MEM/WB afterwards -> val 2.
- Load-use with LOAD_LAT=3: EXE load to r5, ID uses r5 -> hazard_stall high exactly 3 cycles. With src_used_ID bit clear -> no stall.
- Reset mid-HOLD: assert rst in the second stall cycle -> stall 0 that cycle, history cleared, sel 0 next cycle.
- FORWARDING_EN undefined: MEM writes r2, ID reads r2 -> stall asserted, fwd_sel=0.
